mc_ctrl: RTL
============

# mc_ctrl

Multicycle MIPS-subset control unit that drives the datapath and the 32-bit ALU. It decodes the instruction opcode/funct held in the instruction register, steps a Moore FSM through fetch/decode/execute/memory/writeback, and emits the per-cycle datapath enables plus the 3-bit ALU function code (`o_alu_ctrl`) consumed by the ALU's function input. It also counts retired instructions for bring-up and performance checks.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.

- `i_clk`  in  1  clock, rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_op`  in  6  instruction opcode [31:26] from the instruction register.
- `i_funct`  in  6  instruction funct [5:0].
- `i_zero`  in  1  ALU zero flag, result == 0.
- `o_pc_en`  out  1  PC register load enable.
- `o_iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `o_mem_write`  out  1  data memory write strobe.
- `o_ir_write`  out  1  instruction register load.
- `o_reg_dst`  out  1  register write address: 0 = rt, 1 = rd.
- `o_mem_to_reg`  out  1  register write data: 0 = ALUOut, 1 = memory data.
- `o_reg_write`  out  1  register file write strobe.
- `o_alu_src_a`  out  1  ALU A: 0 = PC, 1 = register A.
- `o_alu_src_b`  out  2  ALU B: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `o_pc_src`  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `o_alu_ctrl`  out  3  ALU function: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- `o_illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `o_retired`  out  CNT_W  count of completed instructions.

## Operation
- **States:** IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. The state register is the only FSM storage.
- **Reset:** state is IDLE. Every output is 0, including `o_retired`. IDLE goes to FETCH unconditionally.
- **FETCH:** `o_ir_write` = 1, PC write = 1, `o_alu_src_b` = 01, add, `o_pc_src` = 00. Next state is DECODE.
- **DECODE:** `o_alu_src_b` = 11, add (branch target into ALUOut). Next state depends on `i_op`:
  - lw 100011 and sw 101011 go to MEMADR.
  - R-type 000000 goes to EXEC.
  - beq 000100 goes to BRANCH.
  - addi 001000 goes to ADDIEX.
  - j 000010 goes to JUMP.
  - Any other opcode goes to FETCH, with `o_illegal` = 1 in this DECODE cycle.
- **MEMADR:** `o_alu_src_a` = 1, `o_alu_src_b` = 10, add. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD:** `o_iord` = 1, then MEMWB.
- **MEMWB:** `o_reg_write` = 1, `o_mem_to_reg` = 1, `o_reg_dst` = 0.
- **MEMWR:** `o_iord` = 1, `o_mem_write` = 1.
- **EXEC:** `o_alu_src_a` = 1, `o_alu_src_b` = 00, funct-decoded ALU code, then ALUWB.
- **ALUWB:** `o_reg_write` = 1, `o_reg_dst` = 1.
- **BRANCH:** `o_alu_src_a` = 1, `o_alu_src_b` = 00, sub, `o_pc_src` = 01, branch = 1.
- **ADDIEX:** `o_alu_src_a` = 1, `o_alu_src_b` = 10, add, then ADDIWB.
- **ADDIWB:** `o_reg_write` = 1, `o_reg_dst` = 0.
- **JUMP:** `o_pc_src` = 10, PC write = 1.
- **Return to FETCH:** MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all go to FETCH.
- **PC enable:** `o_pc_en` = pcwrite | (branch & `i_zero`). This is combinational from `i_zero`; all other outputs are pure functions of state.
- **Funct decode (EXEC only):**
  - 100000 gives 010.
  - 100010 gives 110.
  - 100100 gives 000.
  - 100101 gives 001.
  - 101010 gives 111.
  - Any other funct gives 010 with `o_illegal` = 1 for that EXEC cycle; writeback still occurs.
- **Unused outputs:** any output not listed for a state is 0 in that state, and `o_alu_ctrl` defaults to 010.
- **Retire counter:** `o_retired` increments by 1 on the edge leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - It does not increment on an illegal-opcode DECODE→FETCH.
  - It wraps modulo 2^CNT_W, so all-ones goes to 0.

## Timing
- Cycles per instruction, FETCH through the final state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- The first FETCH occurs 1 cycle after reset deassertion, because of the IDLE cycle.
- `i_op` and `i_funct` are sampled in DECODE and EXEC only. They must be stable from the IR load through the end of the instruction.
- `i_zero` is sampled only in BRANCH and is used combinationally for `o_pc_en`.
- **Reset asserted mid-instruction:** state goes to IDLE and all outputs go to 0 immediately (asynchronously); no partial write strobe survives. The counter clears.

## Structure
- **Shared package `mc_pkg`:**
  - State encoding (4-bit localparams).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants.
  - ALU codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, matching the ALU's 3-bit function input.
  - The `o_alu_src_b` and `o_pc_src` select encodings.
- **Sub-module `alu_dec`:** combinational; inputs are the 2-bit aluop (add/sub/funct) and `i_funct`; outputs are `o_alu_ctrl` and the funct-illegal flag. The FSM, the counter and the `o_pc_en` logic stay in `mc_ctrl`.

## Test plan
- **Reset release:** `i_rstn` 0→1, then IDLE for 1 cycle, then FETCH with `o_ir_write` = 1, `o_pc_en` = 1, `o_alu_src_b` = 01, `o_alu_ctrl` = 010, `o_retired` = 0.
- **lw:** `i_op` = 100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMWB shows `o_reg_write` = 1 and `o_mem_to_reg` = 1; `o_retired` becomes 1 after 5 cycles.
- **R-type:** `i_op` = 0, `i_funct` = 101010 → `o_alu_ctrl` = 111 in EXEC. `i_funct` = 100010 → 110. `i_funct` = 000000 → 010 with `o_illegal` = 1 in EXEC.
- **beq:** `i_zero` = 1 → `o_pc_en` = 1, `o_pc_src` = 01 in BRANCH. `i_zero` = 0 → `o_pc_en` = 0. Both cases take 3 cycles and the counter increments.
- **Illegal opcode:** `i_op` = 111111 → `o_illegal` pulses in DECODE for 1 cycle, next state is FETCH, `o_retired` is unchanged.
- **Wrap and mid-instruction reset:**
  - With CNT_W = 4, 16 j instructions return `o_retired` to 0.
  - Asserting `i_rstn` = 0 during MEMWR drops `o_mem_write` to 0 the same cycle and clears the counter.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, opcode/funct constants, ALU codes and mux selects for mc_ctrl
package mc_pkg;
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: maps aluop (add/sub/funct) and funct to the 3-bit ALU code; flags unsupported funct
module alu_dec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);
    logic [2:0] f_ctrl;
    logic       f_ok;
    always_comb begin
        f_ctrl = ALU_ADD;
        f_ok   = 1'b1;
        case (funct)
            FN_ADD:  f_ctrl = ALU_ADD;
            FN_SUB:  f_ctrl = ALU_SUB;
            FN_AND:  f_ctrl = ALU_AND;
            FN_OR:   f_ctrl = ALU_OR;
            FN_SLT:  f_ctrl = ALU_SLT;
            default: f_ok = 1'b0;
        endcase
        alu_ctrl = aluop == ALUOP_SUB ? ALU_SUB : aluop == ALUOP_FUNCT ? f_ctrl : ALU_ADD;
        illegal  = aluop == ALUOP_FUNCT && !f_ok;
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset Moore control FSM (i_op/i_funct/i_zero in; datapath enables, ALU code, illegal pulse, retired count out)
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [5:0]       i_op,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    output logic             o_pc_en,
    output logic             o_iord,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_pc_src,
    output logic [2:0]       o_alu_ctrl,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired
);
    state_t     state, next;
    logic       pc_write, branch, op_bad, fn_bad, retire;
    logic [1:0] aluop;
    logic [2:0] dec_ctrl;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= S_IDLE;
            o_retired <= '0;
        end else begin
            state     <= next;
            o_retired <= retire ? o_retired + CNT_W'(1) : o_retired;
        end
    end
    always_comb begin
        next         = S_FETCH;
        pc_write     = 1'b0;
        branch       = 1'b0;
        op_bad       = 1'b0;
        aluop        = ALUOP_ADD;
        o_iord       = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_REG;
        o_pc_src     = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                o_ir_write  = 1'b1;
                pc_write    = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                next        = S_DECODE;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH;
                next = i_op == OP_LW || i_op == OP_SW ? S_MEMADR :
                       i_op == OP_RTYPE ? S_EXEC :
                       i_op == OP_BEQ   ? S_BRANCH :
                       i_op == OP_ADDI  ? S_ADDIEX :
                       i_op == OP_J     ? S_JUMP : S_FETCH;
                op_bad = next == S_FETCH;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                next        = i_op == OP_SW ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
                next   = S_MEMWB;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                aluop       = ALUOP_FUNCT;
                next        = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                aluop       = ALUOP_SUB;
                o_pc_src    = PCSRC_ALUOUT;
                branch      = 1'b1;
            end
            S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                next        = S_ADDIWB;
            end
            S_ADDIWB: o_reg_write = 1'b1;
            S_JUMP: begin
                o_pc_src = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: next = S_FETCH;
        endcase
    end
    alu_dec u_alu_dec (
        .aluop    (aluop),
        .funct    (i_funct),
        .alu_ctrl (dec_ctrl),
        .illegal  (fn_bad)
    );
    // IDLE is the reset state, where even the ALU code reads 0
    assign o_alu_ctrl = state == S_IDLE ? 3'b000 : dec_ctrl;
    assign o_illegal  = op_bad | fn_bad;
    assign o_pc_en    = pc_write | (branch & i_zero);
    assign retire     = state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP};
endmodule
